// File: rtl/i_buf_controller.sv
// i_buf_controller: captures a vsync/vde qualified 8-bit pixel stream, packs four pixels per word
// and writes whole lines into alternating linebuffer banks, flagging each finished line.
module i_buf_controller #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 480
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic                     vsync,
    input  logic                     vde,
    input  logic [7:0]               i_data,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     we,
    output logic [31:0]              o_data,
    output logic                     line_ready,
    output logic                     line_bank,
    output logic [12:0]              line_num,
    output logic                     frame_start,
    output logic                     frame_done,
    output logic                     line_err
);
    localparam logic [12:0]              DW13  = 13'(DISPLAY_WIDTH);
    localparam logic [12:0]              LAST  = 13'(DISPLAY_HEIGHT - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WPL_A = ADDRESS_WIDTH'(DISPLAY_WIDTH / 4);

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, ACTIVE} state_t;

    state_t      r_state;
    logic        r_vsync_d;
    logic        r_bank;
    logic [12:0] r_pix;
    logic [12:0] r_line;
    logic [23:0] r_sh;

    wire w_vs_fall = r_vsync_d & ~vsync;
    wire w_wr      = (r_pix[1:0] == 2'b11) && (r_pix < DW13);

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= WAIT_FRAME;
            r_vsync_d   <= 1'b0;
            r_bank      <= 1'b0;
            r_pix       <= '0;
            r_line      <= '0;
            r_sh        <= '0;
            addr        <= '0;
            we          <= 1'b0;
            o_data      <= '0;
            line_ready  <= 1'b0;
            line_bank   <= 1'b0;
            line_num    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
        end else begin
            r_vsync_d   <= vsync;
            we          <= 1'b0;
            line_ready  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            // vsync wins over everything, including a line ending on the same edge
            if (w_vs_fall) begin
                frame_start <= 1'b1;
                line_err    <= (r_state == ACTIVE);
                r_line      <= '0;
                r_bank      <= 1'b0;
                r_state     <= WAIT_LINE;
            end else if (r_state == WAIT_LINE && vde) begin
                r_sh    <= {r_sh[15:0], i_data};
                r_pix   <= 13'd1;
                r_state <= ACTIVE;
            end else if (r_state == ACTIVE && vde) begin
                r_sh  <= {r_sh[15:0], i_data};
                r_pix <= (r_pix == '1) ? r_pix : r_pix + 13'd1;
                if (w_wr) begin
                    we     <= 1'b1;
                    addr   <= (r_bank ? WPL_A : '0) + ADDRESS_WIDTH'(r_pix[12:2]);
                    o_data <= {r_sh, i_data};
                end
            end else if (r_state == ACTIVE) begin
                if (r_pix == DW13) begin
                    line_ready <= 1'b1;
                    line_bank  <= r_bank;
                    line_num   <= r_line;
                    r_bank     <= ~r_bank;
                    r_line     <= r_line + 13'd1;
                    frame_done <= (r_line == LAST);
                    r_state    <= (r_line == LAST) ? WAIT_FRAME : WAIT_LINE;
                end else begin
                    line_err <= 1'b1;
                    r_state  <= WAIT_LINE;
                end
            end
        end
    end
endmodule

// File: tb/tb_i_buf_controller.sv
// tb_i_buf_controller: directed checks of line capture, banking, error pulses and resets
// on a reduced 16x4 display so whole frames fit in a short run.
module tb_i_buf_controller;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int DH = 4;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b1;
    logic          vde = 1'b0;
    logic [7:0]    i_data = '0;
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   o_data;
    logic          line_ready;
    logic          line_bank;
    logic [12:0]   line_num;
    logic          frame_start;
    logic          frame_done;
    logic          line_err;

    i_buf_controller #(.ADDRESS_WIDTH(AW), .DISPLAY_WIDTH(DW), .DISPLAY_HEIGHT(DH)) dut (
        .pclk(pclk), .reset(reset), .vsync(vsync), .vde(vde), .i_data(i_data),
        .addr(addr), .we(we), .o_data(o_data), .line_ready(line_ready),
        .line_bank(line_bank), .line_num(line_num), .frame_start(frame_start),
        .frame_done(frame_done), .line_err(line_err)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail = 0;
    int n_we = 0, n_ready = 0, n_err = 0, n_fs = 0, n_fd = 0, n_fs_err = 0;
    logic [12:0] last_num = '0;
    logic        last_bank = 1'b0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (we) begin
            n_we++;
            if (q_addr.size() == 0) check("wr_unexpected", 32'(addr), 32'hFFFF_FFFF);
            else begin
                check("wr_addr", 32'(addr), q_addr.pop_front());
                check("wr_data", o_data, q_data.pop_front());
            end
        end
        if (line_ready) begin
            n_ready++;
            last_num  = line_num;
            last_bank = line_bank;
        end
        if (line_err) n_err++;
        if (frame_start) n_fs++;
        if (frame_done) n_fd++;
        if (frame_start && line_err) n_fs_err++;
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic settle();
        step();
        step();
    endtask

    task automatic pixel(input int i, input int base, input bit bank, input bit exp_wr);
        vde = 1'b1;
        i_data = 8'(base + i);
        if (exp_wr && i % 4 == 3 && i < DW) begin
            q_addr.push_back(32'(int'(bank) * (DW / 4) + i / 4));
            q_data.push_back({8'(base + i - 3), 8'(base + i - 2), 8'(base + i - 1), 8'(base + i)});
        end
        step();
    endtask

    task automatic send_line(input int n, input int base, input bit bank, input bit exp_wr);
        for (int i = 0; i < n; i++) pixel(i, base, bank, exp_wr);
        vde = 1'b0;
        step();
    endtask

    task automatic vsync_fall();
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_addr"}, 32'(addr), 32'h0);
        check({tag, "_odata"}, o_data, 32'h0);
        check({tag, "_pulses"}, {27'b0, we, line_ready, frame_start, frame_done, line_err}, 32'h0);
        check({tag, "_bank_num"}, {18'b0, line_bank, line_num}, 32'h0);
    endtask

    initial begin
        step();
        step();
        check_reset_outs("rst");
        reset = 1'b0;
        step();
        send_line(DW, 0, 1'b0, 1'b0);
        settle();
        check("pre_vsync_we", 32'(n_we), 32'd0);
        check("pre_vsync_pulses", 32'(n_ready + n_err + n_fs + n_fd), 32'd0);
        vsync_fall();
        check("frame_start", 32'(n_fs), 32'd1);
        send_line(DW, 0, 1'b0, 1'b1);
        settle();
        check("l0_ready", 32'(n_ready), 32'd1);
        check("l0_num_bank", {last_num, 3'b0, last_bank}, {13'd0, 3'b0, 1'b0});
        check("l0_writes", 32'(n_we), 32'd4);
        send_line(DW - 4, 32, 1'b1, 1'b1);
        settle();
        check("short_err", 32'(n_err), 32'd1);
        check("short_ready", 32'(n_ready), 32'd1);
        check("short_writes", 32'(n_we), 32'd7);
        send_line(DW, 64, 1'b1, 1'b1);
        settle();
        check("l1_num_bank", {last_num, 3'b0, last_bank}, {13'd1, 3'b0, 1'b1});
        check("l1_no_fd", 32'(n_fd), 32'd0);
        send_line(DW + 3, 100, 1'b0, 1'b1);
        settle();
        check("long_err", 32'(n_err), 32'd2);
        check("long_writes", 32'(n_we), 32'd15);
        send_line(DW, 128, 1'b0, 1'b1);
        send_line(DW, 160, 1'b1, 1'b1);
        settle();
        check("l3_ready", 32'(n_ready), 32'd4);
        check("l3_num_bank", {last_num, 3'b0, last_bank}, {13'(DH - 1), 3'b0, 1'b1});
        check("frame_done", 32'(n_fd), 32'd1);
        send_line(DW, 200, 1'b0, 1'b0);
        settle();
        check("after_fd", 32'(n_we + n_ready + n_err), 32'd29);
        vsync_fall();
        send_line(DW, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) pixel(i, 20, 1'b1, 1'b1);
        vsync = 1'b0;
        vde = 1'b1;
        i_data = 8'd30;
        step();
        vsync = 1'b1;
        vde = 1'b0;
        step();
        settle();
        check("abort_fs_err", 32'(n_fs_err), 32'd1);
        check("abort_err", 32'(n_err), 32'd3);
        check("abort_fs", 32'(n_fs), 32'd3);
        send_line(DW, 50, 1'b0, 1'b1);
        settle();
        check("post_abort_num_bank", {last_num, 3'b0, last_bank}, {13'd0, 3'b0, 1'b0});
        check("post_abort_ready", 32'(n_ready), 32'd6);
        for (int i = 0; i < 6; i++) pixel(i, 70, 1'b1, 1'b1);
        reset = 1'b1;
        vde = 1'b1;
        step();
        check_reset_outs("midrst");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) pixel(i, 80, 1'b0, 1'b0);
        vde = 1'b0;
        step();
        settle();
        check("midrst_writes", 32'(n_we), 32'd34);
        check("midrst_pulses", 32'(n_ready + n_err + n_fs), 32'd12);
        vsync_fall();
        send_line(DW, 90, 1'b0, 1'b1);
        settle();
        check("rst_line_num_bank", {last_num, 3'b0, last_bank}, {13'd0, 3'b0, 1'b0});
        check("final_writes", 32'(n_we), 32'd38);
        check("queue_empty", 32'(q_addr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i_buf_controller.md
# i_buf_controller

Video capture front end: the receiving counterpart of the linebuffer-to-video output path. Samples an 8-bit RAW pixel stream qualified by vsync/vde on the pixel clock, packs four pixels per 32-bit word and writes complete lines into a two-bank linebuffer. Raises a per-line request so the Processing System can copy the finished bank to the framebuffer while the next line fills the other bank.

## Interface

- ADDRESS_WIDTH, 32: linebuffer word-address width; must hold 2*DISPLAY_WIDTH/4 - 1.
- DISPLAY_WIDTH, 640: active pixels per line; must be a multiple of 4.
- DISPLAY_HEIGHT, 480: active lines per frame.

- pclk  input  1  video pixel clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- vsync  input  1  vertical sync, active low (idle high).
- vde  input  1  video data enable; high for active pixels.
- i_data  input  8  RAW pixel value, valid when vde=1.
- addr  output  ADDRESS_WIDTH  linebuffer word address.
- we  output  1  linebuffer write strobe, one cycle per word.
- o_data  output  32  packed word to linebuffer.
- line_ready  output  1  one-cycle pulse: a complete line is in bank line_bank.
- line_bank  output  1  bank of the last completed line.
- line_num  output  13  index (0-based) of the last completed line.
- frame_start  output  1  one-cycle pulse on vsync assertion.
- frame_done  output  1  one-cycle pulse with the line_ready of line DISPLAY_HEIGHT-1.
- line_err  output  1  one-cycle pulse: a line was discarded.

## Operation

- WPL = DISPLAY_WIDTH/4 words per line. Bank b occupies addresses b*WPL .. b*WPL+WPL-1.
- Packing: pixel 4k in o_data[31:24], 4k+1 in [23:16], 4k+2 in [15:8], 4k+3 in [7:0].
- States: WAIT_FRAME, WAIT_LINE, ACTIVE.
- WAIT_FRAME (after reset): vde ignored. vsync falling edge (prev 1, now 0) -> frame_start, line counter=0, bank=0, go WAIT_LINE.
- WAIT_LINE: vde=1 -> capture that pixel as pixel 0, go ACTIVE.
- ACTIVE: each vde=1 cycle captures a pixel; pixel count 13 bits, saturating. On the 4th pixel of a group, write the word at bank*WPL + word index; word index increments. Pixels beyond DISPLAY_WIDTH are not written.
- vde falling edge in ACTIVE: if pixel count == DISPLAY_WIDTH -> line_ready, line_bank=bank, line_num=line counter, bank toggles, line counter increments; if line counter was DISPLAY_HEIGHT-1, also frame_done and go WAIT_FRAME, else WAIT_LINE. Otherwise (short or long line) -> line_err, bank/counter unchanged, go WAIT_LINE. Partial trailing words are never written.
- vsync falling edge in any state other than WAIT_FRAME: frame_start, line counter=0, bank=0, go WAIT_LINE; an in-progress line is aborted with line_err. Takes priority over a simultaneous vde falling edge.
- Lines arriving after frame_done are ignored until the next vsync falling edge.
- Reset values: addr=0, we=0, o_data=0, line_ready=0, line_bank=0, line_num=0, frame_start=0, frame_done=0, line_err=0; state WAIT_FRAME; counters 0. Reset mid-line discards the line and emits no pulse.

## Timing

- All inputs sampled on pclk rising edge; all outputs registered.
- Write latency: 4th pixel of a group sampled at edge N -> we=1 with addr/o_data valid for the cycle following edge N. we is 0 otherwise; addr/o_data hold last values.
- Last word of a line is written the cycle after the sample of its 4th pixel; line_ready follows the edge that samples vde=0, i.e. at least one cycle after the last write.
- frame_start asserts the cycle after the edge that samples vsync=0 following vsync=1.
- Back-to-back lines with one-cycle vde gap are supported at full rate.

## Test plan

- 640x480 frame, i_data=pixel index mod 256 -> 160 writes per line, word 0 of line 0 = 0x00010203 at addr 0; line 1 word 0 at addr 160; line_ready x480, line_bank alternating 0/1, frame_done with line_num=479.
- Line of 636 pixels -> 159 writes, line_err pulse, no line_ready; next good line reuses same bank and line_num.
- Line of 643 pixels -> 160 writes only, line_err, no line_ready.
- vsync asserted mid-line 10 -> line_err + frame_start same cycle, next good line reports line_num=0, line_bank=0.
- vde activity before first vsync after reset -> no writes, no pulses.
- reset asserted at pixel 300 of line 5 -> all outputs at reset values next cycle; vde ignored until vsync falling edge.
